// File: rtl/instruction_loader.sv
// instruction_loader: assembles a framed byte stream into 49-bit instructions,
// validates them and writes them to sequential instruction-memory addresses.
module instruction_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [48:0]       mem_wdata,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   word_count
);
    typedef enum logic [2:0] {IDLE, RECV, WRITE, CKSUM, DONE, ERR} state_t;
    state_t      state;
    logic [2:0]  idx;
    logic [47:0] sh;
    logic [7:0]  fx;
    logic [7:0]  cksum;
    logic [55:0] f;
    logic [4:0]  op;
    logic        legal;
    // f is only meaningful while the 7th byte of a frame is on in_data
    assign f = {sh, in_data};
    assign op = f[48:44];
    assign legal = f[55:49] == 7'd0 && (op <= 5'h0a || (op >= 5'h10 && op <= 5'h12)) && f[43:42] != 2'b11;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            sh         <= '0;
            fx         <= '0;
            cksum      <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'b00;
            word_count <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: if (start) begin
                    state      <= RECV;
                    in_ready   <= 1'b1;
                    busy       <= 1'b1;
                    idx        <= '0;
                    fx         <= '0;
                    cksum      <= '0;
                    word_count <= '0;
                    done       <= 1'b0;
                    err        <= 1'b0;
                    err_code   <= 2'b00;
                end
                RECV: if (in_valid) begin
                    sh  <= {sh[39:0], in_data};
                    fx  <= idx == 3'd6 ? 8'd0 : fx ^ in_data;
                    idx <= idx == 3'd6 ? 3'd0 : idx + 3'd1;
                    if (idx == 3'd6) begin
                        if (f[55]) begin
                            state <= CKSUM;
                        end else if (!legal || word_count[ADDR_W]) begin
                            state    <= ERR;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                            err_code <= legal ? 2'b11 : 2'b01;
                        end else begin
                            state     <= WRITE;
                            in_ready  <= 1'b0;
                            mem_we    <= 1'b1;
                            mem_addr  <= word_count[ADDR_W-1:0];
                            mem_wdata <= f[48:0];
                            cksum     <= cksum ^ fx ^ in_data;
                        end
                    end
                end
                WRITE: begin
                    state      <= RECV;
                    in_ready   <= 1'b1;
                    word_count <= word_count + (ADDR_W+1)'(1);
                end
                CKSUM: if (in_valid) begin
                    state    <= in_data == cksum ? DONE : ERR;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= in_data == cksum;
                    err      <= in_data != cksum;
                    err_code <= in_data == cksum ? 2'b00 : 2'b10;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/instruction_loader.md
# instruction_loader

Byte-stream program loader that writes the instruction memory read by the instruction decoder. It accepts a framed byte stream over a valid/ready handshake and assembles 49-bit instruction words. Each word is checked for a legal opcode and addressing mode, then written to sequential instruction-memory addresses. A trailing checksum closes the session. It sits between the host link (UART/debug port) and the instruction ROM/RAM write port, and runs only while the CPU is held off.

## Interface
- ADDR_W, 8, instruction-memory address width (depth 2^ADDR_W words)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a load session (pulse)
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts byte this cycle
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  49  instruction word {opcode[48:44], mode[43:42], src[41:37], dst[36:32], literal[31:0]}
- mem_we  out  1  write strobe
- busy  out  1  session in progress
- done  out  1  session completed, checksum good (sticky)
- err  out  1  session aborted (sticky)
- err_code  out  2  01 illegal frame, 10 checksum mismatch, 11 memory overflow
- word_count  out  ADDR_W+1  instructions written this session

## Operation
- Byte accepted only on in_valid && in_ready.
- Frame: 7 bytes, MSB first, forming a 56-bit value F. Instruction = F[48:0]. F[55:49] is byte0[7:1].
- End frame: byte0[7]=1. Remaining 6 bytes are accepted and ignored.
- Instruction frame: byte0[7:1]=0. Otherwise illegal.
- Legal opcodes: 00 (NOP), 01–0A, 10–12. Mode 2'b11 is illegal for every opcode.
- Checksum: XOR of all 7 bytes of every instruction frame. End frame and checksum byte are excluded. Cleared on start.
- States:
  - IDLE: start goes to RECV. word_count, checksum, done, err and err_code are cleared.
  - RECV: byte index 0..6, in_ready=1. On the 7th accepted byte, evaluate F in this priority order:
    - end frame goes to CKSUM
    - illegal frame goes to ERR with code 01
    - word_count==2^ADDR_W goes to ERR with code 11
    - otherwise go to WRITE
  - WRITE: one cycle. mem_we=1, mem_addr=word_count[ADDR_W-1:0], mem_wdata=F[48:0], in_ready=0. Then word_count+1 and return to RECV at index 0.
  - CKSUM: in_ready=1. One byte is accepted. If it equals the checksum go to DONE, else go to ERR with code 10.
  - DONE: done=1. ERR: err=1, err_code held. Both states have in_ready=0 and leave only on start (to RECV, with clears) or rst.
- start while busy is ignored.
- busy=1 in RECV, WRITE and CKSUM.
- No partial frame is ever written. Memory is written only from WRITE.

## Timing
- Reset values: in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0, done 0, err 0, err_code 00, word_count 0, state IDLE.
- start sampled at edge E gives busy=1 and in_ready=1 from E+1.
- If the 7th byte is accepted at edge N:
  - mem_we=1 during cycle N..N+1 only.
  - word_count increments at N+1.
  - in_ready is high again from N+1.
- Minimum frame period: 8 cycles (7 accept cycles plus 1 write).
- err, done and err_code are registered and valid the cycle after the deciding byte.
- in_valid gaps of any length are tolerated. Byte index and assembly hold their values.
- rst mid-frame or mid-write: everything returns to reset values next cycle. A write in flight is dropped (mem_we=0 after reset).
- Zero-instruction session (end frame, then checksum 00) gives done=1 and word_count=0.

## Test plan
- ADD immediate, src1, dst2, lit 5:
  - Stimulus: start, then 00 30 22 00 00 00 05, then end frame 80 00 00 00 00 00 00, then checksum 17.
  - Response: one mem_we with mem_addr=0 and mem_wdata=0x00302200000005. done=1, word_count=1, err=0.
- Illegal opcode 0B:
  - Stimulus: frame 00 B0 00 00 00 00 00.
  - Response: err=1, err_code=01, no mem_we, in_ready=0. Then start clears err and in_ready=1.
- Illegal mode or reserved bits:
  - Stimulus: frame 00 3C 22 00 00 00 05, then separately a frame with byte0=02.
  - Response: err_code=01 in each case, no write.
- Checksum mismatch:
  - Stimulus: scenario 1 with checksum byte 18.
  - Response: err=1, err_code=10, done=0, word_count=1 (the write already occurred).
- Overflow with ADDR_W=2:
  - Stimulus: five valid frames.
  - Response: writes to addresses 0..3, word_count=4. The fifth frame gives err_code=11 and no fifth write.
- Backpressure and reset:
  - Stimulus: in_valid toggling every other cycle, then rst after byte 3.
  - Response: outputs at reset values, no mem_we. A restart with a full frame writes address 0 correctly.
